// File: rtl/block_mem_responder_pkg.sv
// Shared encodings and block geometry for the memory responder and the cache FSM.
package block_mem_responder_pkg;

    localparam int BLOCK_W         = 128;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/block_mem_array.sv
// Single-port block store: 2**ADDR_W x 128 bits, per-word write enables,
// registered read port. Contents are never touched by reset; only the read
// register is cleared.
module block_mem_array
    import block_mem_responder_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int INIT_ZERO = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic                       re,
    input  logic [WORDS_PER_BLOCK-1:0] wmask,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [BLOCK_W-1:0]         wdata,
    output logic [BLOCK_W-1:0]         rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [BLOCK_W-1:0] rd_word;

    if (INIT_ZERO != 0) begin : g_zero
        // Zero start-up contents exist only for simulation convenience.
        logic [BLOCK_W-1:0] mem [DEPTH] = '{default: '0};

        // Word-masked write; unmasked words keep their old value.
        always_ff @(posedge clk) begin
            if (we) begin
                for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                    if (wmask[i]) begin
                        mem[addr][i*WORD_W +: WORD_W] <= wdata[i*WORD_W +: WORD_W];
                    end
                end
            end
        end

        assign rd_word = mem[addr];
    end else begin : g_raw
        logic [BLOCK_W-1:0] mem [DEPTH];

        // Word-masked write; unmasked words keep their old value.
        always_ff @(posedge clk) begin
            if (we) begin
                for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                    if (wmask[i]) begin
                        mem[addr][i*WORD_W +: WORD_W] <= wdata[i*WORD_W +: WORD_W];
                    end
                end
            end
        end

        assign rd_word = mem[addr];
    end

    // Read register holds its value until the next read is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rd_word;
        end
    end

endmodule

// File: rtl/block_mem_responder.sv
// Single-clock memory responder for cache block refill/writeback.
// A request seen in IDLE is latched, counted down for LATENCY cycles, and
// the array access happens on the edge entering DONE so that read data and
// written data are both visible in the cycle where complete is high.
module block_mem_responder
    import block_mem_responder_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int LATENCY   = 4,
    parameter int INIT_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        wmask,
    input  logic [127:0]      din,
    output logic [127:0]      dout,
    output logic              complete,
    output logic              busy
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t              state;
    state_t              state_d;
    logic [3:0]          count;
    logic [3:0]          count_d;

    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [3:0]          lat_wmask;
    logic [BLOCK_W-1:0]  lat_din;

    logic                op_we;
    logic [ADDR_W-1:0]   op_addr;
    logic [3:0]          op_wmask;
    logic [BLOCK_W-1:0]  op_din;
    logic                enter_done;
    logic                arr_we;
    logic                arr_re;

    // Control state; complete and busy are registered from the next state so
    // they line up exactly with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            complete <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            count    <= count_d;
            complete <= (state_d == ST_DONE);
            busy     <= (state_d != ST_IDLE);
        end
    end

    // Next-state and latency countdown.
    always_comb begin
        state_d = state;
        count_d = count;
        case (state)
            ST_IDLE: begin
                if (re || we) begin
                    count_d = LAT_M1;
                    state_d = (LATENCY > 1) ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                count_d = count - 4'd1;
                if (count == 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the request at acceptance; write wins when both re and we are set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wmask <= '0;
            lat_din   <= '0;
        end else if (state == ST_IDLE && (re || we)) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wmask <= wmask;
            lat_din   <= din;
        end
    end

    // With LATENCY=1 DONE is entered on the accepting edge itself, so the
    // live request must be used in IDLE; otherwise the latched copy is used.
    always_comb begin
        op_we    = lat_we;
        op_addr  = lat_addr;
        op_wmask = lat_wmask;
        op_din   = lat_din;
        if (state == ST_IDLE) begin
            op_we    = we;
            op_addr  = addr;
            op_wmask = wmask;
            op_din   = din;
        end
    end

    assign enter_done = (state_d == ST_DONE) && (state != ST_DONE);
    assign arr_we     = enter_done && op_we;
    assign arr_re     = enter_done && !op_we;

    block_mem_array #(
        .ADDR_W    (ADDR_W),
        .INIT_ZERO (INIT_ZERO)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .re    (arr_re),
        .wmask (op_wmask),
        .addr  (op_addr),
        .wdata (op_din),
        .rdata (dout)
    );

endmodule

// File: tb/tb_block_mem_responder.sv
// Bench for block_mem_responder: a LATENCY=4 instance driven from a vector
// table through a scoreboard queue, and a LATENCY=1 instance for held-request
// back-to-back operation.
module tb_block_mem_responder;

    localparam logic [127:0] D1  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] AA  = {16{8'hAA}};
    localparam logic [127:0] D2  = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
    localparam logic [127:0] MSK = 128'hAAAAAAAA_22222222_AAAAAAAA_44444444;
    localparam logic [127:0] CC  = {16{8'hCC}};
    localparam logic [127:0] F5  = {32{4'h5}};
    localparam logic [127:0] S7  = {32{4'h7}};
    localparam logic [127:0] N9  = {32{4'h9}};
    localparam logic [127:0] FF  = {32{4'hF}};
    localparam logic [127:0] VB  = {8{16'hB1B2}};

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    logic         re_a = 1'b0, we_a = 1'b0;
    logic [7:0]   addr_a = '0;
    logic [3:0]   wmask_a = '0;
    logic [127:0] din_a = '0;
    logic [127:0] dout_a;
    logic         complete_a, busy_a;

    logic         re_b = 1'b0, we_b = 1'b0;
    logic [7:0]   addr_b = '0;
    logic [3:0]   wmask_b = '0;
    logic [127:0] din_b = '0;
    logic [127:0] dout_b;
    logic         complete_b, busy_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [127:0] dout;
        int           cyc;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic         r;
        logic         w;
        logic [7:0]   a;
        logic [3:0]   m;
        logic [127:0] d;
        logic [127:0] exp;
        bit           scr;
    } vec_t;
    vec_t tbl[13];

    block_mem_responder #(.ADDR_W(8), .LATENCY(4), .INIT_ZERO(1)) dut_a (
        .clk(clk), .rst(rst), .re(re_a), .we(we_a), .addr(addr_a),
        .wmask(wmask_a), .din(din_a), .dout(dout_a),
        .complete(complete_a), .busy(busy_a)
    );

    block_mem_responder #(.ADDR_W(8), .LATENCY(1), .INIT_ZERO(1)) dut_b (
        .clk(clk), .rst(rst), .re(re_b), .we(we_b), .addr(addr_b),
        .wmask(wmask_b), .din(din_b), .dout(dout_b),
        .complete(complete_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one transaction on dut_a, push its expectation, and pop/compare
    // when complete appears. scr scrambles addr/din/wmask while in flight.
    task automatic do_op_a(input int idx, input logic r, input logic w, input logic [7:0] a,
                           input logic [3:0] m, input logic [127:0] d,
                           input logic [127:0] exp, input bit scr);
        sb_t e;
        int  n;
        @(negedge clk);
        re_a = r; we_a = w; addr_a = a; wmask_a = m; din_a = d;
        e.dout = exp;
        e.cyc  = cyc + 4;
        sbq.push_back(e);
        @(negedge clk);
        chk($sformatf("busy_after_accept[%0d]", idx), {127'd0, busy_a}, 128'd1);
        n = 0;
        while (complete_a !== 1'b1 && n < 20) begin
            if (scr) begin
                addr_a  = 8'($urandom);
                din_a   = {$urandom, $urandom, $urandom, $urandom};
                wmask_a = 4'($urandom);
            end
            @(negedge clk);
            n++;
        end
        if (complete_a !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL timeout[%0d]: complete not seen, got 0, expected 1", idx);
            void'(sbq.pop_front());
        end else begin
            e = sbq.pop_front();
            chk($sformatf("dout[%0d]", idx), dout_a, e.dout);
            chk($sformatf("latency[%0d]", idx), 128'(cyc), 128'(e.cyc));
        end
        re_a = 1'b0;
        we_a = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic expc;

        tbl[0]  = '{1'b0, 1'b1, 8'h05, 4'hF, D1,   128'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'h05, 4'h0, '0,   D1,     1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'h10, 4'hF, AA,   D1,     1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'h10, 4'h5, D2,   D1,     1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'h10, 4'h0, '0,   MSK,    1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'h21, 4'hF, CC,   MSK,    1'b0};
        tbl[6]  = '{1'b1, 1'b1, 8'h20, 4'hF, F5,   MSK,    1'b1};
        tbl[7]  = '{1'b1, 1'b0, 8'h20, 4'h0, '0,   F5,     1'b1};
        tbl[8]  = '{1'b1, 1'b0, 8'h21, 4'h0, '0,   CC,     1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'h05, 4'h0, '0,   D1,     1'b0};
        tbl[10] = '{1'b0, 1'b1, 8'h30, 4'hF, S7,   D1,     1'b0};
        tbl[11] = '{1'b0, 1'b1, 8'h30, 4'h0, N9,   D1,     1'b0};
        tbl[12] = '{1'b1, 1'b0, 8'h30, 4'h0, '0,   S7,     1'b0};

        // Reset for 3 cycles, then idle for 10.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_complete_a", {127'd0, complete_a}, 128'd0);
            chk("idle_busy_a",     {127'd0, busy_a},     128'd0);
            chk("idle_dout_a",     dout_a,               128'd0);
            chk("idle_complete_b", {127'd0, complete_b}, 128'd0);
            chk("idle_busy_b",     {127'd0, busy_b},     128'd0);
            chk("idle_dout_b",     dout_b,               128'd0);
        end

        for (int i = 0; i < 13; i++) begin
            do_op_a(i, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].m, tbl[i].d, tbl[i].exp, tbl[i].scr);
        end

        // Abort a write to 0x30 by resetting in its second BUSY cycle.
        @(negedge clk);
        re_a = 1'b0; we_a = 1'b1; addr_a = 8'h30; wmask_a = 4'hF; din_a = FF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy",     {127'd0, busy_a},     128'd0);
        chk("abort_complete", {127'd0, complete_a}, 128'd0);
        chk("abort_dout",     dout_a,               128'd0);
        we_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_complete", {127'd0, complete_a}, 128'd0);
        end
        do_op_a(100, 1'b1, 1'b0, 8'h30, 4'h0, '0, S7, 1'b0);
        do_op_a(101, 1'b1, 1'b0, 8'h10, 4'h0, '0, MSK, 1'b0);

        // LATENCY=1: write one block, then hold re and expect a pulse every 2 cycles.
        @(negedge clk);
        we_b = 1'b1; addr_b = 8'h01; wmask_b = 4'hF; din_b = VB;
        @(negedge clk);
        chk("b_write_complete", {127'd0, complete_b}, 128'd1);
        we_b = 1'b0;
        @(negedge clk);
        chk("b_write_idle", {127'd0, complete_b}, 128'd0);
        re_b = 1'b1;
        k = cyc;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            expc = ((cyc - k) % 2) == 1;
            chk($sformatf("b_complete[%0d]", i), {127'd0, complete_b}, {127'd0, expc});
            chk($sformatf("b_dout[%0d]", i), dout_b, VB);
        end
        re_b = 1'b0;

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 128'(sbq.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_mem_responder.md
Name: block_mem_responder

Overview:
- Memory-side responder for the cache's block refill/writeback interface.
- Serves 128-bit (4-word) block reads and word-masked block writes after a fixed, parameterised latency, and signals `complete`.
- Sits below the cache as the synthesizable single-clock backing store. The cache is the initiator; this block is the responder.
- Replaces the dual-clock DRAM model in single-clock builds.

Parameters:
- ADDR_W, 8, block address width; storage depth is 2**ADDR_W blocks of 128 bits.
- LATENCY, 4, cycles from request acceptance to `complete` pulse; legal range 1..15.
- INIT_ZERO, 1, if 1 the array is zero-initialised at elaboration (simulation only; reset never clears the array).

Ports:
- clk  in  1  sole clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- re  in  1  read request, level; initiator holds it until `complete`.
- we  in  1  write request, level; initiator holds it until `complete`.
- addr  in  ADDR_W  block address.
- wmask  in  4  word enables for writes; bit i enables din[32i+31:32i].
- din  in  128  write data block.
- dout  out  128  read data block; registered; valid from the `complete` cycle of a read until the next read completes.
- complete  out  1  one-cycle pulse ending each transaction.
- busy  out  1  high while a transaction is in flight (BUSY or DONE).

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0, complete=0, busy=0, dout=0, latched request cleared. Array contents are untouched.
- States:
  - IDLE: if (re|we), latch op, addr, wmask and din; count=LATENCY-1; go to BUSY if LATENCY>1, else go to DONE.
  - BUSY: decrement count; when count reaches 1, go to DONE.
  - DONE: complete=1 for exactly this cycle; go to IDLE.
- Latency: request seen in IDLE at edge N gives complete=1 during the cycle after edge N+LATENCY-1. complete is therefore high LATENCY cycles after request acceptance.
- Array update and dout capture occur on the edge entering DONE, so dout and the written data are visible in the complete cycle.
- Read: dout <= mem[latched addr] on entry to DONE.
- Write: for each i with wmask[i]=1, mem[addr] word i <= din word i. Unmasked words are preserved. dout is unchanged.
- Simultaneous re&we: write takes priority. It is treated as a write only, and dout is not updated.
- Changes to re/we/addr/din during BUSY/DONE are ignored; only latched values are used.
- After DONE the block returns to IDLE. A re/we still high in IDLE is accepted as a new transaction at that edge. The minimum request-to-request spacing is LATENCY+1 cycles.
- wmask=0 write: completes normally with no array change.
- Reset mid-transaction: the transaction is aborted, no array write occurs, and complete is never pulsed for it.
- busy = (state != IDLE), registered, consistent with the state register.
- Address wrap: none. addr covers the full array, and any value is legal.
- count is a 4-bit unsigned counter; no underflow is possible by construction.

Decomposition:
- Shared package/defines file holds:
  - state encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2;
  - BLOCK_W=128, WORD_W=32, WORDS_PER_BLOCK=4.
  - These are shared with the cache FSM.
- One natural sub-module, block_mem_array: a 2**ADDR_W x 128 single-port array with 4 word-write enables and a registered read. The FSM/latency counter stays in the top.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release, no requests for 10 cycles -> complete=0, busy=0, dout=0 throughout.
- Full write then read, LATENCY=4:
  - we=1, addr=8'h05, wmask=4'hF, din=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 -> complete pulses exactly 4 cycles after acceptance.
  - Then re=1, addr=8'h05 -> complete after 4 cycles with dout equal to that value.
- Masked write:
  - Preload addr 8'h10 with 128'hAAAA..AA.
  - Write wmask=4'b0101, din=128'h1111_1111_2222_2222_3333_3333_4444_4444.
  - Read back -> 128'hAAAAAAAA_22222222_AAAAAAAA_44444444.
- Priority and stability:
  - re=we=1, addr=8'h20, din=all 5s, wmask=F -> treated as write, dout unchanged.
  - Toggle addr during BUSY -> later read of 8'h20 returns all 5s; other addresses are unchanged.
- Reset mid-op: start write to 8'h30 with din=all Fs, pull rst=0 on the second BUSY cycle -> complete never pulses, busy=0 immediately, and a subsequent read of 8'h30 returns its prior contents.
- Back-to-back held re, LATENCY=1: keep re=1 with addr=8'h01 -> complete pulses every 2 cycles, dout stable and equal to mem[1].
